// File: rtl/issue_steer_queue_if.sv
// rtl/issue_steer_queue_if.sv - decode/issue handshake bundle for issue_steer_queue
//
// Purpose: groups every non-clock signal of the steering queue.
// Ports (master = decode + downstream side, slave = queue):
//   flush        squash queue and output stage
//   in_valid     decode slot valids, [0] older
//   in_ready     queue can take a full pair
//   in_payload   opaque per-slot instruction bits
//   in_is_mem    per-slot load/store class
//   in_is_br     per-slot branch/jump class
//   in_rd_we     per-slot destination write enable
//   in_rd/rs1/rs2  per-slot register indices
//   issue_stall  downstream hold
//   bp_valid/bp_payload  branch/ALU pipe output
//   mp_valid/mp_payload  memory/ALU pipe output
//   older_is_bp  BP instruction is the older of a dual issue
//   count        current queue occupancy
interface issue_steer_queue_if #(
    parameter int PAYLOAD_W = 96,
    parameter int DEPTH     = 4,
    parameter int REG_W     = 5
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                      flush;
    logic [1:0]                in_valid;
    logic                      in_ready;
    logic [1:0][PAYLOAD_W-1:0] in_payload;
    logic [1:0]                in_is_mem;
    logic [1:0]                in_is_br;
    logic [1:0]                in_rd_we;
    logic [1:0][REG_W-1:0]     in_rd;
    logic [1:0][REG_W-1:0]     in_rs1;
    logic [1:0][REG_W-1:0]     in_rs2;
    logic                      issue_stall;
    logic                      bp_valid;
    logic [PAYLOAD_W-1:0]      bp_payload;
    logic                      mp_valid;
    logic [PAYLOAD_W-1:0]      mp_payload;
    logic                      older_is_bp;
    logic [CNT_W-1:0]          count;

    modport master (
        output flush, in_valid, in_payload, in_is_mem, in_is_br, in_rd_we,
               in_rd, in_rs1, in_rs2, issue_stall,
        input  in_ready, bp_valid, bp_payload, mp_valid, mp_payload,
               older_is_bp, count
    );

    modport slave (
        input  flush, in_valid, in_payload, in_is_mem, in_is_br, in_rd_we,
               in_rd, in_rs1, in_rs2, issue_stall,
        output in_ready, bp_valid, bp_payload, mp_valid, mp_payload,
               older_is_bp, count
    );
endinterface

// File: rtl/issue_steer_queue.sv
// rtl/issue_steer_queue.sv - dual-issue steering queue feeding the BP and MP pipes
//
// Purpose: circular FIFO of decoded instructions; each unstalled cycle the
// oldest one or two entries are steered to the branch/ALU pipe (BP) and the
// memory/ALU pipe (MP) through a registered output stage.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   io   issue_steer_queue_if.slave (decode pair in, BP/MP out, count)
module issue_steer_queue #(
    parameter int PAYLOAD_W = 96,
    parameter int DEPTH     = 4,
    parameter int REG_W     = 5
) (
    input logic                clk,
    input logic                rst,
    issue_steer_queue_if.slave io
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // entry storage
    logic [PAYLOAD_W-1:0] r_payload [DEPTH];
    logic [REG_W-1:0]     r_rd      [DEPTH];
    logic [REG_W-1:0]     r_rs1     [DEPTH];
    logic [REG_W-1:0]     r_rs2     [DEPTH];
    logic [DEPTH-1:0]     r_is_mem;
    logic [DEPTH-1:0]     r_is_br;
    logic [DEPTH-1:0]     r_rd_we;

    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;

    // output stage
    logic                 r_bp_valid;
    logic [PAYLOAD_W-1:0] r_bp_payload;
    logic                 r_mp_valid;
    logic [PAYLOAD_W-1:0] r_mp_payload;
    logic                 r_older_is_bp;

    logic                 w_in_ready;
    logic                 w_enq0;
    logic                 w_enq1;
    logic [CNT_W-1:0]     w_enq_n;
    logic [CNT_W-1:0]     w_deq_n;
    logic [PTR_W-1:0]     w_tail1;
    logic [PTR_W-1:0]     w_head1;
    logic                 w_have_a;
    logic                 w_have_b;
    logic                 w_a_mem;
    logic                 w_a_br;
    logic                 w_b_mem;
    logic                 w_b_br;
    logic                 w_raw;
    logic                 w_dual;
    logic                 w_a_to_mp;
    logic                 w_bp_v_n;
    logic                 w_mp_v_n;
    logic [PAYLOAD_W-1:0] w_a_pay;
    logic [PAYLOAD_W-1:0] w_b_pay;

    // Ready only when a whole pair fits; based on registered count, so a
    // same-cycle dequeue never widens it.
    assign w_in_ready = (r_count <= CNT_W'(DEPTH - 2));
    assign w_enq0     = w_in_ready & io.in_valid[0];
    assign w_enq1     = w_enq0 & io.in_valid[1];
    assign w_enq_n    = w_enq1 ? CNT_W'(2) : (w_enq0 ? CNT_W'(1) : '0);

    // Pointers wrap for free because DEPTH is a power of two.
    assign w_tail1 = r_tail + PTR_W'(1);
    assign w_head1 = r_head + PTR_W'(1);

    assign w_have_a = (r_count != '0);
    assign w_have_b = (r_count >= CNT_W'(2));

    // A mem flag wins over a branch flag, so each entry has exactly one class.
    assign w_a_mem = r_is_mem[r_head];
    assign w_a_br  = ~r_is_mem[r_head] & r_is_br[r_head];
    assign w_b_mem = r_is_mem[w_head1];
    assign w_b_br  = ~r_is_mem[w_head1] & r_is_br[w_head1];

    assign w_raw = r_rd_we[r_head] && (r_rd[r_head] != '0) &&
                   ((r_rs1[w_head1] == r_rd[r_head]) || (r_rs2[w_head1] == r_rd[r_head]));

    // Branch A ends the group; mem+mem would need two MP slots.
    assign w_dual = w_have_b & ~w_a_br & ~w_raw & ~(w_a_mem & w_b_mem);

    // A leaves BP for MP when it is mem, or when an ALU A must make room for a branch B.
    assign w_a_to_mp = w_a_mem | (w_dual & w_b_br);

    assign w_bp_v_n = w_have_a & (~w_a_to_mp | w_dual);
    assign w_mp_v_n = w_have_a & (w_a_to_mp | w_dual);
    assign w_a_pay  = r_payload[r_head];
    assign w_b_pay  = r_payload[w_head1];

    assign w_deq_n = (io.issue_stall | ~w_have_a) ? '0 : (w_dual ? CNT_W'(2) : CNT_W'(1));

    // Entry storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (!io.flush) begin
            if (w_enq0) begin
                r_payload[r_tail] <= io.in_payload[0];
                r_rd[r_tail]      <= io.in_rd[0];
                r_rs1[r_tail]     <= io.in_rs1[0];
                r_rs2[r_tail]     <= io.in_rs2[0];
                r_is_mem[r_tail]  <= io.in_is_mem[0];
                r_is_br[r_tail]   <= io.in_is_br[0];
                r_rd_we[r_tail]   <= io.in_rd_we[0];
            end
            if (w_enq1) begin
                r_payload[w_tail1] <= io.in_payload[1];
                r_rd[w_tail1]      <= io.in_rd[1];
                r_rs1[w_tail1]     <= io.in_rs1[1];
                r_rs2[w_tail1]     <= io.in_rs2[1];
                r_is_mem[w_tail1]  <= io.in_is_mem[1];
                r_is_br[w_tail1]   <= io.in_is_br[1];
                r_rd_we[w_tail1]   <= io.in_rd_we[1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_bp_valid    <= 1'b0;
            r_bp_payload  <= '0;
            r_mp_valid    <= 1'b0;
            r_mp_payload  <= '0;
            r_older_is_bp <= 1'b0;
        end else if (io.flush) begin
            // Payloads are left alone so an idle port keeps a stable value.
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_bp_valid <= 1'b0;
            r_mp_valid <= 1'b0;
        end else begin
            r_tail  <= r_tail + PTR_W'(w_enq_n);
            r_head  <= r_head + PTR_W'(w_deq_n);
            r_count <= r_count + w_enq_n - w_deq_n;
            if (!io.issue_stall) begin
                r_bp_valid <= w_bp_v_n;
                r_mp_valid <= w_mp_v_n;
                if (w_bp_v_n) begin
                    r_bp_payload <= w_a_to_mp ? w_b_pay : w_a_pay;
                end
                if (w_mp_v_n) begin
                    r_mp_payload <= w_a_to_mp ? w_a_pay : w_b_pay;
                end
                if (w_have_a) begin
                    r_older_is_bp <= ~w_a_to_mp;
                end
            end
        end
    end

    assign io.in_ready    = w_in_ready;
    assign io.bp_valid    = r_bp_valid;
    assign io.bp_payload  = r_bp_payload;
    assign io.mp_valid    = r_mp_valid;
    assign io.mp_payload  = r_mp_payload;
    assign io.older_is_bp = r_older_is_bp;
    assign io.count       = r_count;
endmodule

// File: tb/tb_issue_steer_queue.sv
// tb/tb_issue_steer_queue.sv - self-checking bench for issue_steer_queue
module tb_issue_steer_queue;
    localparam int PAYLOAD_W = 96;
    localparam int DEPTH     = 4;
    localparam int REG_W     = 5;
    localparam int CNT_W     = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    issue_steer_queue_if #(.PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH), .REG_W(REG_W)) io();
    issue_steer_queue #(.PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH), .REG_W(REG_W)) dut (
        .clk(clk), .rst(rst), .io(io)
    );

    typedef struct packed {
        logic [PAYLOAD_W-1:0] pay;
        logic                 mem;
        logic                 br;
        logic                 we;
        logic [REG_W-1:0]     rd;
        logic [REG_W-1:0]     rs1;
        logic [REG_W-1:0]     rs2;
    } ent_t;

    // reference model: program-ordered list of waiting instructions
    ent_t                 q[$];
    logic                 m_bpv, m_mpv, m_older;
    logic [PAYLOAD_W-1:0] m_bp_pay, m_mp_pay;
    int                   n_cmp = 0;
    int                   n_bad = 0;

    // 0 = ALU, 1 = branch, 2 = memory
    function automatic int cls(input ent_t e);
        if (e.mem) return 2;
        if (e.br) return 1;
        return 0;
    endfunction

    function automatic ent_t slot(input int i);
        ent_t e;
        e.pay = io.in_payload[i]; e.mem = io.in_is_mem[i]; e.br = io.in_is_br[i];
        e.we = io.in_rd_we[i]; e.rd = io.in_rd[i]; e.rs1 = io.in_rs1[i]; e.rs2 = io.in_rs2[i];
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        m_bpv = 0; m_mpv = 0; m_older = 0; m_bp_pay = '0; m_mp_pay = '0;
    endtask

    // Advance the model over the coming edge using the driven inputs, then step the DUT.
    task automatic tick();
        ent_t a, b;
        bit   rdy, two, raw;
        if (io.flush) begin
            q.delete(); m_bpv = 0; m_mpv = 0;
        end else begin
            rdy = (q.size() <= DEPTH - 2);
            if (!io.issue_stall) begin
                m_bpv = 0; m_mpv = 0;
                if (q.size() > 0) begin
                    a = q[0]; two = 0;
                    if (q.size() >= 2 && cls(a) != 1) begin
                        b = q[1];
                        raw = a.we && a.rd != 0 && (b.rs1 == a.rd || b.rs2 == a.rd);
                        if (!raw && !(cls(a) == 2 && cls(b) == 2)) two = 1;
                    end
                    if (two) begin
                        m_bpv = 1; m_mpv = 1;
                        if (cls(a) == 2 || cls(b) == 1) begin
                            m_mp_pay = a.pay; m_bp_pay = b.pay; m_older = 0;
                        end else begin
                            m_bp_pay = a.pay; m_mp_pay = b.pay; m_older = 1;
                        end
                        void'(q.pop_front()); void'(q.pop_front());
                    end else begin
                        if (cls(a) == 2) begin m_mpv = 1; m_mp_pay = a.pay; m_older = 0; end
                        else begin m_bpv = 1; m_bp_pay = a.pay; m_older = 1; end
                        void'(q.pop_front());
                    end
                end
            end
            if (rdy && io.in_valid[0]) begin
                q.push_back(slot(0));
                if (io.in_valid[1]) q.push_back(slot(1));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [PAYLOAD_W-1:0] p, input logic mem,
                            input logic br, input logic we, input logic [REG_W-1:0] rd,
                            input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2);
        io.in_payload[i] = p; io.in_is_mem[i] = mem; io.in_is_br[i] = br;
        io.in_rd_we[i] = we; io.in_rd[i] = rd; io.in_rs1[i] = rs1; io.in_rs2[i] = rs2;
    endtask

    task automatic idle();
        io.in_valid = 2'b00;
        set_slot(0, '0, 0, 0, 0, 0, 0, 0);
        set_slot(1, '0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        io.flush = 0; io.issue_stall = 0; idle();
        model_reset();
        #12;
        n_cmp++; if (io.bp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_bp_valid got %0b want 0", io.bp_valid); end
        n_cmp++; if (io.mp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mp_valid got %0b want 0", io.mp_valid); end
        n_cmp++; if (io.bp_payload !== '0) begin n_bad++; $display("FAIL reset_bp_payload got %h want 0", io.bp_payload); end
        n_cmp++; if (io.mp_payload !== '0) begin n_bad++; $display("FAIL reset_mp_payload got %h want 0", io.mp_payload); end
        n_cmp++; if (io.older_is_bp !== 1'b0) begin n_bad++; $display("FAIL reset_older got %0b want 0", io.older_is_bp); end
        n_cmp++; if (io.count !== '0) begin n_bad++; $display("FAIL reset_count got %0d want 0", io.count); end
        n_cmp++; if (io.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %0b want 1", io.in_ready); end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_mem_alu();
        set_slot(0, 96'hA1, 1, 0, 1, 5, 1, 2);
        set_slot(1, 96'hB1, 0, 0, 1, 6, 3, 4);
        io.in_valid = 2'b11;
        tick(); idle();
        n_cmp++; if (io.bp_valid !== 1'b0 || io.mp_valid !== 1'b0) begin n_bad++; $display("FAIL mem_alu_early got bp=%0b mp=%0b want 0 0", io.bp_valid, io.mp_valid); end
        n_cmp++; if (io.count !== CNT_W'(2)) begin n_bad++; $display("FAIL mem_alu_count1 got %0d want 2", io.count); end
        tick();
        n_cmp++; if (io.bp_valid !== 1'b1 || io.mp_valid !== 1'b1) begin n_bad++; $display("FAIL mem_alu_valid got bp=%0b mp=%0b want 1 1", io.bp_valid, io.mp_valid); end
        n_cmp++; if (io.mp_payload !== 96'hA1) begin n_bad++; $display("FAIL mem_alu_mp_pay got %h want a1", io.mp_payload); end
        n_cmp++; if (io.bp_payload !== 96'hB1) begin n_bad++; $display("FAIL mem_alu_bp_pay got %h want b1", io.bp_payload); end
        n_cmp++; if (io.older_is_bp !== 1'b0) begin n_bad++; $display("FAIL mem_alu_older got %0b want 0", io.older_is_bp); end
        n_cmp++; if (io.count !== '0) begin n_bad++; $display("FAIL mem_alu_count2 got %0d want 0", io.count); end
    endtask

    task automatic test_raw();
        set_slot(0, 96'hA2, 0, 0, 1, 7, 1, 2);
        set_slot(1, 96'hB2, 0, 0, 1, 8, 3, 7);
        io.in_valid = 2'b11;
        tick(); idle(); tick();
        n_cmp++; if (io.bp_valid !== 1'b1 || io.mp_valid !== 1'b0) begin n_bad++; $display("FAIL raw_first_valid got bp=%0b mp=%0b want 1 0", io.bp_valid, io.mp_valid); end
        n_cmp++; if (io.bp_payload !== 96'hA2) begin n_bad++; $display("FAIL raw_first_pay got %h want a2", io.bp_payload); end
        tick();
        n_cmp++; if (io.bp_valid !== 1'b1 || io.mp_valid !== 1'b0 || io.bp_payload !== 96'hB2) begin n_bad++; $display("FAIL raw_second got bp=%0b mp=%0b pay=%h want 1 0 b2", io.bp_valid, io.mp_valid, io.bp_payload); end
        // rd = 0 never creates a dependency
        set_slot(0, 96'hA3, 0, 0, 1, 0, 1, 2);
        set_slot(1, 96'hB3, 0, 0, 1, 8, 0, 0);
        io.in_valid = 2'b11;
        tick(); idle(); tick();
        n_cmp++; if (io.bp_valid !== 1'b1 || io.mp_valid !== 1'b1) begin n_bad++; $display("FAIL raw_x0_valid got bp=%0b mp=%0b want 1 1", io.bp_valid, io.mp_valid); end
        n_cmp++; if (io.bp_payload !== 96'hA3 || io.mp_payload !== 96'hB3 || io.older_is_bp !== 1'b1) begin n_bad++; $display("FAIL raw_x0_route got bp=%h mp=%h older=%0b want a3 b3 1", io.bp_payload, io.mp_payload, io.older_is_bp); end
    endtask

    task automatic test_swap_branch();
        set_slot(0, 96'hA4, 0, 0, 1, 9, 1, 2);
        set_slot(1, 96'hB4, 0, 1, 0, 0, 3, 4);
        io.in_valid = 2'b11;
        tick(); idle(); tick();
        n_cmp++; if (io.bp_valid !== 1'b1 || io.mp_valid !== 1'b1) begin n_bad++; $display("FAIL swap_valid got bp=%0b mp=%0b want 1 1", io.bp_valid, io.mp_valid); end
        n_cmp++; if (io.mp_payload !== 96'hA4 || io.bp_payload !== 96'hB4 || io.older_is_bp !== 1'b0) begin n_bad++; $display("FAIL swap_route got mp=%h bp=%h older=%0b want a4 b4 0", io.mp_payload, io.bp_payload, io.older_is_bp); end
        set_slot(0, 96'hA5, 0, 1, 0, 0, 1, 2);
        set_slot(1, 96'hB5, 0, 0, 1, 10, 3, 4);
        io.in_valid = 2'b11;
        tick(); idle(); tick();
        n_cmp++; if (io.bp_valid !== 1'b1 || io.mp_valid !== 1'b0 || io.bp_payload !== 96'hA5) begin n_bad++; $display("FAIL br_first got bp=%0b mp=%0b pay=%h want 1 0 a5", io.bp_valid, io.mp_valid, io.bp_payload); end
        n_cmp++; if (io.count !== CNT_W'(1)) begin n_bad++; $display("FAIL br_count got %0d want 1", io.count); end
        tick();
        n_cmp++; if (io.bp_valid !== 1'b1 || io.mp_valid !== 1'b0 || io.bp_payload !== 96'hB5) begin n_bad++; $display("FAIL br_second got bp=%0b mp=%0b pay=%h want 1 0 b5", io.bp_valid, io.mp_valid, io.bp_payload); end
    endtask

    task automatic test_full_wrap();
        logic [PAYLOAD_W-1:0] p [4];
        for (int i = 0; i < 4; i++) p[i] = PAYLOAD_W'(96'hC0 + i);
        io.issue_stall = 1;
        set_slot(0, p[0], 1, 0, 1, 1, 0, 0); set_slot(1, p[1], 1, 0, 1, 2, 0, 0);
        io.in_valid = 2'b11; tick();
        set_slot(0, p[2], 1, 0, 1, 3, 0, 0); set_slot(1, p[3], 1, 0, 1, 4, 0, 0);
        tick();
        n_cmp++; if (io.count !== CNT_W'(4) || io.in_ready !== 1'b0) begin n_bad++; $display("FAIL full_state got count=%0d ready=%0b want 4 0", io.count, io.in_ready); end
        set_slot(0, 96'hDEAD, 0, 0, 0, 0, 0, 0); set_slot(1, 96'hBEEF, 0, 0, 0, 0, 0, 0);
        tick();
        n_cmp++; if (io.count !== CNT_W'(4)) begin n_bad++; $display("FAIL full_no_accept got count=%0d want 4", io.count); end
        idle(); io.issue_stall = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (io.mp_valid !== 1'b1 || io.bp_valid !== 1'b0 || io.mp_payload !== p[i]) begin n_bad++; $display("FAIL wrap_issue%0d got mp=%0b bp=%0b pay=%h want 1 0 %h", i, io.mp_valid, io.bp_valid, io.mp_payload, p[i]); end
            n_cmp++; if (io.count !== CNT_W'(3 - i) || io.in_ready !== ((3 - i) <= 2)) begin n_bad++; $display("FAIL wrap_count%0d got count=%0d ready=%0b want %0d %0b", i, io.count, io.in_ready, 3 - i, (3 - i) <= 2); end
        end
    endtask

    task automatic test_flush();
        io.issue_stall = 1;
        set_slot(0, 96'hE0, 0, 0, 1, 1, 0, 0); set_slot(1, 96'hE1, 0, 0, 1, 2, 0, 0);
        io.in_valid = 2'b11; tick();
        io.in_valid = 2'b01; set_slot(0, 96'hE2, 0, 0, 1, 3, 0, 0); tick();
        n_cmp++; if (io.count !== CNT_W'(3) || io.mp_valid !== 1'b1) begin n_bad++; $display("FAIL flush_pre got count=%0d mp=%0b want 3 1", io.count, io.mp_valid); end
        io.flush = 1; io.in_valid = 2'b11;
        set_slot(0, 96'hE3, 0, 0, 0, 0, 0, 0); set_slot(1, 96'hE4, 1, 0, 0, 0, 0, 0);
        tick();
        n_cmp++; if (io.count !== '0 || io.bp_valid !== 1'b0 || io.mp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_edge got count=%0d bp=%0b mp=%0b want 0 0 0", io.count, io.bp_valid, io.mp_valid); end
        io.flush = 0; io.issue_stall = 0; idle(); tick();
        n_cmp++; if (io.count !== '0 || io.bp_valid !== 1'b0 || io.mp_valid !== 1'b0) begin n_bad++; $display("FAIL flush_dropped got count=%0d bp=%0b mp=%0b want 0 0 0", io.count, io.bp_valid, io.mp_valid); end
    endtask

    task automatic test_async_reset();
        set_slot(0, 96'hF0, 1, 0, 1, 1, 0, 0); set_slot(1, 96'hF1, 0, 0, 1, 2, 0, 0);
        io.in_valid = 2'b11; tick();
        set_slot(0, 96'hF2, 0, 0, 1, 3, 0, 0); set_slot(1, 96'hF3, 0, 0, 1, 4, 0, 0);
        tick(); idle();
        n_cmp++; if (io.bp_valid !== 1'b1 || io.mp_valid !== 1'b1) begin n_bad++; $display("FAIL arst_pre got bp=%0b mp=%0b want 1 1", io.bp_valid, io.mp_valid); end
        #2 rst = 1;
        #1;
        n_cmp++; if (io.bp_valid !== 1'b0 || io.mp_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valids got bp=%0b mp=%0b want 0 0", io.bp_valid, io.mp_valid); end
        n_cmp++; if (io.count !== '0) begin n_bad++; $display("FAIL arst_count got %0d want 0", io.count); end
        model_reset();
        @(negedge clk); rst = 0;
    endtask

    task automatic test_random();
        int r;
        for (int cyc = 0; cyc < 400; cyc++) begin
            io.issue_stall = ($urandom_range(0, 3) == 0);
            io.flush       = ($urandom_range(0, 40) == 0);
            io.in_valid    = 2'($urandom_range(0, 3));
            for (int s = 0; s < 2; s++) begin
                r = $urandom_range(0, 2);
                set_slot(s, {$urandom, $urandom, $urandom}, r == 2, r == 1, 1'($urandom_range(0, 1)),
                         REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)), REG_W'($urandom_range(0, 3)));
            end
            tick();
            n_cmp++; if (io.bp_valid !== m_bpv || io.mp_valid !== m_mpv) begin n_bad++; $display("FAIL rnd_valid cyc %0d got bp=%0b mp=%0b want %0b %0b", cyc, io.bp_valid, io.mp_valid, m_bpv, m_mpv); end
            n_cmp++; if (io.bp_payload !== m_bp_pay || io.mp_payload !== m_mp_pay) begin n_bad++; $display("FAIL rnd_payload cyc %0d got bp=%h mp=%h want %h %h", cyc, io.bp_payload, io.mp_payload, m_bp_pay, m_mp_pay); end
            n_cmp++; if (io.count !== CNT_W'(q.size()) || io.in_ready !== (q.size() <= DEPTH - 2)) begin n_bad++; $display("FAIL rnd_count cyc %0d got count=%0d ready=%0b want %0d", cyc, io.count, io.in_ready, q.size()); end
            if (m_bpv && m_mpv) begin
                n_cmp++; if (io.older_is_bp !== m_older) begin n_bad++; $display("FAIL rnd_older cyc %0d got %0b want %0b", cyc, io.older_is_bp, m_older); end
            end
        end
        io.flush = 0; io.issue_stall = 0; idle();
    endtask

    initial begin
        test_reset();
        test_mem_alu();
        test_raw();
        test_swap_branch();
        test_full_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/issue_steer_queue.md
# issue_steer_queue

Parametrised dual-issue steering queue between decode and the two execution pipelines: the branch/ALU pipe (BP) and the memory/ALU pipe (MP). It buffers decoded instruction pairs in a circular FIFO and steers the oldest one or two entries to the correct pipe, swapping slots when needed. It enforces in-order issue, intra-pair RAW and structural hazards, and records relative age so writeback can order the two pipes.

## Interface
- `PAYLOAD_W`, 96: opaque packed operand/control bits per instruction (operands, imm, ALU op, PC, load/store type).
- `DEPTH`, 4: queue entries; power of two, ≥ 2.
- `REG_W`, 5: architectural register index width.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous squash of queue and output stage.
- `in_valid` in 2: decode slots; [0] is older. `in_valid[1]` is ignored unless `in_valid[0]` is set.
- `in_ready` out 1: high when free entries ≥ 2.
- `in_payload[1:0]` in PAYLOAD_W each.
- `in_is_mem`, `in_is_br` in 2: load/store class and branch/jump class. Both low means plain ALU.
- `in_rd[1:0]`, `in_rs1[1:0]`, `in_rs2[1:0]` in REG_W each; `in_rd_we` in 2.
- `issue_stall` in 1: downstream hold.
- `bp_valid` out 1, `bp_payload` out PAYLOAD_W.
- `mp_valid` out 1, `mp_payload` out PAYLOAD_W.
- `older_is_bp` out 1: when both valids are high, 1 means the BP instruction is older.
- `count` out $clog2(DEPTH)+1: current occupancy.

## Operation
- Storage is a circular buffer with head/tail pointers that wrap modulo DEPTH. `count` is updated as count + enq − deq.
- **Enqueue:** occurs when `in_ready` && `in_valid[0]`. It writes 1 or 2 entries at the tail in program order. `in_ready` is taken from registered `count` before any same-cycle dequeue, so it is conservative.
- **Issue decision:** evaluated each cycle from stored entries only. Head entry is A, head+1 is B; B is used only if count ≥ 2.
  - count = 0 → nothing issues.
  - A mem → MP.
  - A branch → BP.
  - A ALU → BP, except when it is swapped to MP by rule (c).
- **B dual-issues only if all of the following hold:**
  - A is not branch/jump.
  - B does not RAW-depend on A: no `A.rd_we` && A.rd ≠ 0 && (B.rs1 == A.rd || B.rs2 == A.rd).
  - A pipe-compatible slot exists for B:
    - (a) A mem, B non-mem → B to BP.
    - (b) A ALU, B ALU or mem → B to MP.
    - (c) A ALU, B branch → A to MP, B to BP.
    - A mem with B mem is a structural conflict → single issue.
- **Dequeue:** removes the issued entries (1 or 2) when `issue_stall` is low.
- **`older_is_bp`:** 1 when A was sent to BP, 0 when A was sent to MP.
- **Hazard scope:** dependencies on already-issued instructions are not checked here; downstream forwarding owns them.

## Timing
- Output stage is registered. On each edge with `issue_stall` low, `bp_*`, `mp_*` and `older_is_bp` load the decision and the corresponding entries dequeue.
- With `issue_stall` high, outputs hold their values, nothing dequeues, and enqueue proceeds if `in_ready` is high.
- Latency: a pair accepted at edge k is visible on the outputs after edge k+1 (2 cycles from `in_valid` to output valid), assuming an empty queue.
- An entry written at edge k is not eligible for issue at edge k.
- **Full:** count > DEPTH−2 → `in_ready` = 0. Input is not accepted; no overwrite.
- **Empty:** valids go 0 at the next unstalled edge.
- **Flush:** takes priority over enqueue, issue and stall. At the next edge count = 0, pointers = 0, `bp_valid` = `mp_valid` = 0, and any same-cycle enqueue is dropped.
- **Reset values:** `bp_valid` = `mp_valid` = 0, payloads 0, `older_is_bp` = 0, `count` = 0, `in_ready` = 1, pointers 0.
- Reset asserted mid-operation clears everything asynchronously.
- Payload registers of an invalid port are don't-care after reset, but the bench expects them stable.

## Test plan
- **Mem + ALU pair:** A = lw (is_mem, rd = 5), B = add (rs1 = 3, rs2 = 4). Required: after 2 cycles `mp_valid` = `bp_valid` = 1, `mp_payload` = A, `older_is_bp` = 0, count returns to 0.
- **RAW pair:** A = add rd = 7, B = sub rs2 = 7. Required: A alone on BP, then B on BP the next cycle. A second case with rd = 0 instead must dual-issue.
- **Swap and branch rules:**
  - A = ALU, B = beq → A on MP, B on BP, `older_is_bp` = 0.
  - A = beq, B = ALU → A alone on BP.
- **Structural conflict and wrap:** DEPTH = 4, stall asserted, enqueue two mem+mem pairs.
  - Required: count = 4 and `in_ready` = 0.
  - After stall release: issue one entry per cycle over 4 cycles, head wraps, `in_ready` returns to 1 when count ≤ 2.
- **Flush with stall and enqueue:** count = 3, `issue_stall` = 1, `flush` = 1, with `in_valid` = 2'b11 in the same cycle. Required next edge: count = 0, both valids 0, incoming pair dropped.
- **Asynchronous reset mid-stream:** assert `rst` between edges with outputs valid. Required: valids drop immediately without waiting for a clock edge; `count` = 0.
